// File: rtl/dc_huff_sched_if.sv
// Bundle of every signal between the DC Huffman scheduler and its neighbours
// apart from clock and reset.
//   dc_valid/dc_ready/dc_value/comp_id/restart : coefficient input handshake
//   tbl_size/tbl_lumenb/tbl_chromu/tbl_chromv  : request to the shared DC table
//   tbl_lcode/tbl_llength/tbl_ccode/tbl_clength: combinational table response
//   out_valid/out_ready                        : result handshake to the bit packer
//   huff_code/huff_len/amp_bits/amp_len        : result payload
// Modports: slave = the scheduler, master = the surrounding system.
interface dc_huff_sched_if #(
    parameter int DC_W   = 11,
    parameter int CODE_W = 11
) ();
    logic              dc_valid;
    logic              dc_ready;
    logic [DC_W-1:0]   dc_value;
    logic [1:0]        comp_id;
    logic              restart;
    logic [3:0]        tbl_size;
    logic              tbl_lumenb;
    logic              tbl_chromu;
    logic              tbl_chromv;
    logic [8:0]        tbl_lcode;
    logic [3:0]        tbl_llength;
    logic [10:0]       tbl_ccode;
    logic [3:0]        tbl_clength;
    logic              out_valid;
    logic              out_ready;
    logic [CODE_W-1:0] huff_code;
    logic [3:0]        huff_len;
    logic [CODE_W-1:0] amp_bits;
    logic [3:0]        amp_len;

    modport slave (
        input  dc_valid, dc_value, comp_id, restart,
        input  tbl_lcode, tbl_llength, tbl_ccode, tbl_clength,
        input  out_ready,
        output dc_ready, tbl_size, tbl_lumenb, tbl_chromu, tbl_chromv,
        output out_valid, huff_code, huff_len, amp_bits, amp_len
    );

    modport master (
        output dc_valid, dc_value, comp_id, restart,
        output tbl_lcode, tbl_llength, tbl_ccode, tbl_clength,
        output out_ready,
        input  dc_ready, tbl_size, tbl_lumenb, tbl_chromu, tbl_chromv,
        input  out_valid, huff_code, huff_len, amp_bits, amp_len
    );
endinterface

// File: rtl/dc_huff_sched.sv
// DC-coefficient entropy coding sequencer for Y/U/V blocks.
// Keeps one DC predictor per component, forms DIFF = DC - PRED, derives the
// size category, queries the shared DC-difference Huffman table and hands
// {Huffman code, amplitude bits} to the bit packer.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : dc_huff_sched_if.slave (input handshake, table request/response,
//           output handshake and payload)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | dc_ready high; accept a coefficient, update its predictor
// CALC  | size category from DIFF; drive tbl_size and component enable
// LOOK  | capture table response and amplitude bits; release the table
// OUT   | out_valid high, payload frozen until out_ready
module dc_huff_sched #(
    parameter int DC_W   = 11,
    parameter int CODE_W = 11
) (
    input  logic        clk,
    input  logic        reset,
    dc_huff_sched_if.slave bus
);
    localparam int DW = DC_W + 1;

    typedef enum logic [1:0] {IDLE, CALC, LOOK, OUT} state_t;

    state_t            state_q;
    logic [1:0]        comp_q;
    logic [DW-1:0]     diff_q;
    logic [3:0]        size_q;
    logic [DC_W-1:0]   pred_y_q, pred_u_q, pred_v_q;
    logic              dc_ready_q, out_valid_q;
    logic [3:0]        tbl_size_q;
    logic              lumenb_q, chromu_q, chromv_q;
    logic [CODE_W-1:0] huff_code_q, amp_bits_q;
    logic [3:0]        huff_len_q, amp_len_q;

    logic [DC_W-1:0]   pred_sel;
    logic [DW-1:0]     diff_d;
    logic [DW-1:0]     mag;
    logic [3:0]        size_d;
    logic [DW-2:0]     amp_full;
    logic [CODE_W-1:0] amp_src;
    logic [CODE_W-1:0] amp_d;

    always_comb begin
        // A restart in the same cycle as an accept predicts from zero.
        pred_sel = '0;
        if (!bus.restart) begin
            case (bus.comp_id)
                2'd0:    pred_sel = pred_y_q;
                2'd1:    pred_sel = pred_u_q;
                2'd2:    pred_sel = pred_v_q;
                default: pred_sel = '0;
            endcase
        end
        diff_d = {bus.dc_value[DC_W-1], bus.dc_value} - {pred_sel[DC_W-1], pred_sel};

        mag = diff_q[DW-1] ? (~diff_q + DW'(1)) : diff_q;
        size_d = '0;
        for (int i = 0; i < DW; i++) begin
            if (mag[i]) size_d = 4'(i + 1);
        end

        // Negative DIFF sends the low bits of DIFF-1 (one's complement).
        // Only bits below size are kept, so the sign bit itself is not needed.
        amp_full = diff_q[DW-2:0] - (DW-1)'(diff_q[DW-1]);
        amp_src  = CODE_W'(amp_full);
        amp_d    = '0;
        for (int i = 0; i < CODE_W; i++) begin
            amp_d[i] = (i < int'(size_q)) ? amp_src[i] : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            comp_q      <= '0;
            diff_q      <= '0;
            size_q      <= '0;
            pred_y_q    <= '0;
            pred_u_q    <= '0;
            pred_v_q    <= '0;
            dc_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            tbl_size_q  <= '0;
            lumenb_q    <= 1'b0;
            chromu_q    <= 1'b0;
            chromv_q    <= 1'b0;
            huff_code_q <= '0;
            huff_len_q  <= '0;
            amp_bits_q  <= '0;
            amp_len_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.restart) begin
                        pred_y_q <= '0;
                        pred_u_q <= '0;
                        pred_v_q <= '0;
                    end
                    if (bus.dc_valid) begin
                        comp_q     <= bus.comp_id;
                        diff_q     <= diff_d;
                        dc_ready_q <= 1'b0;
                        state_q    <= CALC;
                        // Later assignment overrides a same-cycle restart clear.
                        case (bus.comp_id)
                            2'd0:    pred_y_q <= bus.dc_value;
                            2'd1:    pred_u_q <= bus.dc_value;
                            2'd2:    pred_v_q <= bus.dc_value;
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    size_q     <= size_d;
                    tbl_size_q <= size_d;
                    lumenb_q   <= (comp_q == 2'd0);
                    chromu_q   <= (comp_q == 2'd1);
                    chromv_q   <= (comp_q == 2'd2);
                    state_q    <= LOOK;
                end
                LOOK: begin
                    case (comp_q)
                        2'd0: begin
                            huff_code_q <= CODE_W'({bus.tbl_lcode, 2'b00}) << (CODE_W - 11);
                            huff_len_q  <= bus.tbl_llength;
                        end
                        2'd1, 2'd2: begin
                            huff_code_q <= CODE_W'(bus.tbl_ccode) << (CODE_W - 11);
                            huff_len_q  <= bus.tbl_clength;
                        end
                        default: begin
                            huff_code_q <= '0;
                            huff_len_q  <= '0;
                        end
                    endcase
                    if (comp_q == 2'd3) begin
                        amp_bits_q <= '0;
                        amp_len_q  <= '0;
                    end else begin
                        amp_bits_q <= amp_d;
                        amp_len_q  <= size_q;
                    end
                    tbl_size_q  <= '0;
                    lumenb_q    <= 1'b0;
                    chromu_q    <= 1'b0;
                    chromv_q    <= 1'b0;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        dc_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dc_ready   = dc_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.tbl_size   = tbl_size_q;
    assign bus.tbl_lumenb = lumenb_q;
    assign bus.tbl_chromu = chromu_q;
    assign bus.tbl_chromv = chromv_q;
    assign bus.huff_code  = huff_code_q;
    assign bus.huff_len   = huff_len_q;
    assign bus.amp_bits   = amp_bits_q;
    assign bus.amp_len    = amp_len_q;
endmodule

// File: tb/tb_dc_huff_sched.sv
// Testbench for dc_huff_sched: models the standard JPEG DC Huffman tables as
// the external combinational table, keeps its own predictors, and scores every
// result against a queue of expected outputs.
module tb_dc_huff_sched;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dc_huff_sched_if #(.DC_W(11), .CODE_W(11)) bus ();
    dc_huff_sched #(.DC_W(11), .CODE_W(11)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [10:0] code;
        logic [3:0]  len;
        logic [10:0] amp;
        logic [3:0]  alen;
    } res_t;

    int lum_code [12] = '{'h0, 'h2, 'h3, 'h4, 'h5, 'h6, 'he, 'h1e, 'h3e, 'h7e, 'hfe, 'h1fe};
    int lum_len  [12] = '{2, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8, 9};
    int chr_code [12] = '{'h0, 'h1, 'h2, 'h6, 'he, 'h1e, 'h3e, 'h7e, 'hfe, 'h1fe, 'h3fe, 'h7fe};
    int chr_len  [12] = '{2, 2, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};

    res_t sb[$];
    int   pred_m [3];
    int   n_checks = 0;
    int   n_fail   = 0;

    // External DC table: codes left-aligned, all zero when not enabled.
    always_comb begin
        bus.tbl_lcode   = '0;
        bus.tbl_llength = '0;
        bus.tbl_ccode   = '0;
        bus.tbl_clength = '0;
        if (bus.tbl_size <= 4'd11) begin
            if (bus.tbl_lumenb) begin
                bus.tbl_lcode   = 9'(lum_code[bus.tbl_size] << (9 - lum_len[bus.tbl_size]));
                bus.tbl_llength = 4'(lum_len[bus.tbl_size]);
            end
            if (bus.tbl_chromu || bus.tbl_chromv) begin
                bus.tbl_ccode   = 11'(chr_code[bus.tbl_size] << (11 - chr_len[bus.tbl_size]));
                bus.tbl_clength = 4'(chr_len[bus.tbl_size]);
            end
        end
    end

    function automatic res_t model_exp(input int c, input int diff);
        res_t r;
        int mag, sz, a, code, len;
        r = '0;
        if (c == 3) return r;
        mag = (diff < 0) ? -diff : diff;
        sz = 0;
        while (mag > 0) begin
            sz++;
            mag = mag >> 1;
        end
        if (sz == 0)        a = 0;
        else if (diff >= 0) a = diff;
        else                a = diff + (1 << sz) - 1;
        if (c == 0) begin code = lum_code[sz]; len = lum_len[sz]; end
        else        begin code = chr_code[sz]; len = chr_len[sz]; end
        r.code = 11'(code << (11 - len));
        r.len  = 4'(len);
        r.amp  = 11'(a);
        r.alen = 4'(sz);
        return r;
    endfunction

    function automatic string fmt(input res_t r);
        return $sformatf("code=%h len=%0d amp=%h alen=%0d", r.code, r.len, r.amp, r.alen);
    endfunction

    task automatic accept(input int c, input int dc, input bit rs);
        int guard;
        int diff;
        guard = 0;
        @(negedge clk);
        while (!bus.dc_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.dc_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout dc_ready stayed 0, required 1");
        end
        if (rs) pred_m = '{0, 0, 0};
        if (c < 3) begin
            diff = dc - pred_m[c];
            pred_m[c] = dc;
        end else begin
            diff = dc;
        end
        sb.push_back(model_exp(c, diff));
        bus.dc_valid = 1'b1;
        bus.dc_value = 11'(dc);
        bus.comp_id  = 2'(c);
        bus.restart  = rs;
        @(posedge clk);
        #1;
        bus.dc_valid = 1'b0;
        bus.restart  = 1'b0;
    endtask

    task automatic wait_out(input bit ack, output res_t act, output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            lat++;
            if (bus.out_valid) ok = 1'b1;
        end
        act = {bus.huff_code, bus.huff_len, bus.amp_bits, bus.amp_len};
        if (ok && ack) begin
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [38:0] obs;
        reset = 1'b1;
        bus.dc_valid = 1'b0; bus.dc_value = '0; bus.comp_id = '0;
        bus.restart = 1'b0; bus.out_ready = 1'b0;
        pred_m = '{0, 0, 0};
        repeat (3) @(negedge clk);
        obs = {bus.dc_ready, bus.out_valid, bus.tbl_size, bus.tbl_lumenb, bus.tbl_chromu,
               bus.tbl_chromv, bus.huff_code, bus.huff_len, bus.amp_bits, bus.amp_len};
        n_checks++;
        if (obs !== 39'h40_0000_0000) begin
            n_fail++;
            $display("FAIL reset_state got %h required %h", obs, 39'h40_0000_0000);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        res_t act, exp;
        int lat;
        bit ok;
        accept(0, 5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.tbl_size, bus.tbl_lumenb, bus.tbl_chromu, bus.tbl_chromv} !== 7'b0011_100) begin
            n_fail++;
            $display("FAIL t1_table_req got size=%0d en=%b%b%b required size=3 en=100", bus.tbl_size,
                     bus.tbl_lumenb, bus.tbl_chromu, bus.tbl_chromv);
        end
        wait_out(1'b1, act, lat, ok);
        exp = sb.pop_front();
        n_checks++;
        if (!ok || (lat + 2) != 3) begin
            n_fail++;
            $display("FAIL t1_latency got %0d edges (valid=%0b) required 3", lat + 2, ok);
        end
        n_checks++;
        if (act !== exp || exp !== {11'b100_0000_0000, 4'd3, 11'b101, 4'd3}) begin
            n_fail++;
            $display("FAIL t1_y5 got %s required %s", fmt(act), fmt(exp));
        end
    endtask

    task automatic test_diff();
        res_t act, exp;
        int lat;
        bit ok;
        accept(0, 2, 1'b0);
        wait_out(1'b1, act, lat, ok);
        exp = sb.pop_front();
        n_checks++;
        if (!ok || act !== exp || exp !== {11'b011_0000_0000, 4'd3, 11'b0, 4'd2}) begin
            n_fail++;
            $display("FAIL t2_neg_diff got %s required %s", fmt(act), fmt(exp));
        end
    endtask

    task automatic test_chroma();
        res_t act, exp;
        int lat;
        bit ok;
        int cs [4] = '{1, 2, 1, 2};
        int ds [4] = '{0, -1024, 37, 500};
        for (int i = 0; i < 4; i++) begin
            accept(cs[i], ds[i], 1'b0);
            if (i == 1) begin
                @(negedge clk);
                @(negedge clk);
                n_checks++;
                if ({bus.tbl_size, bus.tbl_lumenb, bus.tbl_chromu, bus.tbl_chromv} !== 7'b1011_001) begin
                    n_fail++;
                    $display("FAIL t3_v_table_req got size=%0d en=%b%b%b required size=11 en=001",
                             bus.tbl_size, bus.tbl_lumenb, bus.tbl_chromu, bus.tbl_chromv);
                end
                wait_out(1'b1, act, lat, ok);
                lat += 2;
            end else begin
                wait_out(1'b1, act, lat, ok);
            end
            exp = sb.pop_front();
            n_checks++;
            if (!ok || lat != 3 || act !== exp) begin
                n_fail++;
                $display("FAIL t3_chroma_%0d got %s lat=%0d required %s lat=3", i, fmt(act), lat, fmt(exp));
            end
        end
    endtask

    task automatic test_stall();
        res_t act, exp, now;
        int lat;
        bit ok;
        accept(0, -50, 1'b0);
        wait_out(1'b0, act, lat, ok);
        bus.dc_valid = 1'b1;
        bus.dc_value = 11'd300;
        bus.comp_id  = 2'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            now = {bus.huff_code, bus.huff_len, bus.amp_bits, bus.amp_len};
            n_checks++;
            if (!bus.out_valid || bus.dc_ready || now !== act) begin
                n_fail++;
                $display("FAIL t4_stall_%0d got valid=%b ready=%b %s required valid=1 ready=0 %s",
                         i, bus.out_valid, bus.dc_ready, fmt(now), fmt(act));
            end
        end
        bus.dc_valid = 1'b0;
        exp = sb.pop_front();
        n_checks++;
        if (!ok || act !== exp) begin
            n_fail++;
            $display("FAIL t4_stall_data got %s required %s", fmt(act), fmt(exp));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.dc_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_release got valid=%b ready=%b required valid=0 ready=1", bus.out_valid, bus.dc_ready);
        end
    endtask

    task automatic test_restart();
        res_t act, exp;
        int lat;
        bit ok;
        // Restart alongside dc_valid, then restart while in OUT, then restart alone.
        accept(0, 100, 1'b0);
        wait_out(1'b1, act, lat, ok);
        void'(sb.pop_front());
        accept(0, 100, 1'b1);
        wait_out(1'b1, act, lat, ok);
        exp = sb.pop_front();
        n_checks++;
        if (!ok || act !== exp || exp.alen != 4'd7) begin
            n_fail++;
            $display("FAIL t5_restart_with_valid got %s required %s", fmt(act), fmt(exp));
        end
        accept(0, 120, 1'b0);
        wait_out(1'b0, act, lat, ok);
        bus.restart = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.restart = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        exp = sb.pop_front();
        n_checks++;
        if (!ok || act !== exp) begin
            n_fail++;
            $display("FAIL t5_y120 got %s required %s", fmt(act), fmt(exp));
        end
        accept(0, 130, 1'b0);
        wait_out(1'b1, act, lat, ok);
        exp = sb.pop_front();
        n_checks++;
        if (!ok || act !== exp) begin
            n_fail++;
            $display("FAIL t5_restart_in_out_ignored got %s required %s", fmt(act), fmt(exp));
        end
        accept(1, 40, 1'b0);
        wait_out(1'b1, act, lat, ok);
        void'(sb.pop_front());
        @(negedge clk);
        bus.restart = 1'b1;
        @(posedge clk);
        #1;
        bus.restart = 1'b0;
        pred_m = '{0, 0, 0};
        accept(1, 9, 1'b0);
        wait_out(1'b1, act, lat, ok);
        exp = sb.pop_front();
        n_checks++;
        if (!ok || act !== exp) begin
            n_fail++;
            $display("FAIL t5_restart_alone got %s required %s", fmt(act), fmt(exp));
        end
    endtask

    task automatic test_reset_mid();
        res_t act, exp;
        int lat;
        bit ok;
        int cs [4] = '{0, 1, 3, 0};
        int ds [4] = '{7, 5, 55, 10};
        accept(2, 77, 1'b0);
        wait_out(1'b1, act, lat, ok);
        void'(sb.pop_front());
        accept(0, 33, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.out_valid, bus.dc_ready, bus.tbl_lumenb, bus.tbl_size} !== 7'b0100_000) begin
            n_fail++;
            $display("FAIL t6_async_reset got valid=%b ready=%b lumenb=%b size=%0d required 0 1 0 0",
                     bus.out_valid, bus.dc_ready, bus.tbl_lumenb, bus.tbl_size);
        end
        sb.delete();
        pred_m = '{0, 0, 0};
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            accept(cs[i], ds[i], 1'b0);
            wait_out(1'b1, act, lat, ok);
            exp = sb.pop_front();
            n_checks++;
            if (!ok || act !== exp) begin
                n_fail++;
                $display("FAIL t6_after_reset_%0d got %s required %s", i, fmt(act), fmt(exp));
            end
        end
    endtask

    task automatic test_back_to_back();
        res_t act, exp;
        int lat;
        bit ok;
        int c, dc;
        bit rs;
        for (int i = 0; i < 24; i++) begin
            c  = int'($urandom_range(0, 3));
            dc = int'($urandom_range(0, 2047)) - 1024;
            rs = ($urandom_range(0, 7) == 0);
            accept(c, dc, rs);
            wait_out(1'b1, act, lat, ok);
            exp = sb.pop_front();
            n_checks++;
            if (!ok || lat != 3 || act !== exp) begin
                n_fail++;
                $display("FAIL b2b_%0d c=%0d dc=%0d got %s lat=%0d required %s lat=3",
                         i, c, dc, fmt(act), lat, fmt(exp));
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_diff();
        test_chroma();
        test_stall();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
